// File: rtl/cdc_hs_pkg.sv
// Shared types and default constants for the cdc_hs transmitter family.
package cdc_hs_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef logic [1:0] hs_state_t;

  localparam hs_state_t IDLE   = 2'd0;
  localparam hs_state_t REQ_HI = 2'd1;
  localparam hs_state_t REQ_LO = 2'd2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer, cleared to 0 by synchronous reset.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clki,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clki) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// 4-phase req/ack handshake transmitter in the clki domain.
// Define CDC_HS_TX_TIMEOUT_EN to add the watchdog abort (err pulse).
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clki,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              done,
  output logic              err
);

  // state  | meaning
  // IDLE   | no transfer; accepts a word when synchronized ack is low
  // REQ_HI | req_o high, data_o held, waiting for ack_s high
  // REQ_LO | req_o low, waiting for ack_s low to close the handshake

  hs_state_t         state;
  hs_state_t         state_nx;
  logic              req_nx;
  logic [DATA_W-1:0] data_nx;
  logic              done_nx;
  logic              err_nx;
  logic              ack_s;
  logic              accept;
  logic              wd_expired;

  // legal ranges: SYNC_STAGES 2..4, TIMEOUT_CYC >= 1
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 1) begin : g_illegal_params
  end

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clki (clki),
    .rst  (rst),
    .d    (ack_i),
    .q    (ack_s)
  );

  assign s_ready = (state == IDLE) & ~ack_s;
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_nx = state;
    req_nx   = req_o;
    data_nx  = data_o;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = REQ_HI;
          req_nx   = 1'b1;
          data_nx  = s_data;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          state_nx = REQ_LO;
          req_nx   = 1'b0;
        end else if (wd_expired) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          err_nx   = 1'b1;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (wd_expired) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state  <= IDLE;
      req_o  <= 1'b0;
      data_o <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      req_o  <= req_nx;
      data_o <= data_nx;
      done   <= done_nx;
      err    <= err_nx;
    end
  end

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] wd_cnt;
  logic             wd_entry;

  // the entry cycle of a wait state only clears; counting starts the cycle after
  always_ff @(posedge clki) begin
    if (rst) begin
      wd_cnt   <= '0;
      wd_entry <= 1'b0;
    end else if (state_nx != state) begin
      wd_cnt   <= '0;
      wd_entry <= (state_nx != IDLE);
    end else if (wd_entry) begin
      wd_cnt   <= '0;
      wd_entry <= 1'b0;
    end else if (state != IDLE && wd_cnt != CNT_LIM) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign wd_expired = (wd_cnt == CNT_LIM);
`else
  assign wd_expired = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Randomized + directed bench for cdc_hs_tx against a behavioural handshake model.
`timescale 1ns/1ps
module tb_cdc_hs_tx;

  localparam int DW = 32;
  localparam int SS = 2;
  localparam int TO = 8;
`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clki    = 1'b0;
  logic          rst     = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          s_ready;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          done;
  logic          err;
  logic          ack_loop = 1'b0;
  logic          ack_drv  = 1'b0;
  logic          ack_i;

  assign ack_i = ack_loop ? req_o : ack_drv;

  always #5 clki = ~clki;

  cdc_hs_tx #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clki    (clki),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .req_o   (req_o),
    .data_o  (data_o),
    .ack_i   (ack_i),
    .done    (done),
    .err     (err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic checkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: a transfer is busy from accept until the ack level it
  // awaits (high, then low) is seen through an SS-deep delay of ack_i.
  bit            m_on   = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_high = 1'b0;
  bit            m_req  = 1'b0;
  bit            m_done = 1'b0;
  bit            m_err  = 1'b0;
  bit            m_ready = 1'b1;
  bit            m_acks;
  logic [DW-1:0] m_data = '0;
  bit            m_hist[SS];
  int            m_start = 0;

  always @(posedge clki) begin
    if (rst) begin
      m_on   = 1'b1;
      m_busy = 1'b0;
      m_req  = 1'b0;
      m_data = '0;
      m_done = 1'b0;
      m_err  = 1'b0;
      for (int i = 0; i < SS; i++) m_hist[i] = 1'b0;
    end else begin
      m_acks = m_hist[SS-1];
      m_done = 1'b0;
      m_err  = 1'b0;
      if (!m_busy) begin
        if (s_valid && !m_acks) begin
          m_busy  = 1'b1;
          m_high  = 1'b1;
          m_req   = 1'b1;
          m_data  = s_data;
          m_start = cyc;
        end
      end else if (m_acks == m_high) begin
        if (m_high) begin
          m_req   = 1'b0;
          m_high  = 1'b0;
          m_start = cyc;
        end else begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (TO_EN && (cyc - m_start >= TO + 2)) begin
        m_busy = 1'b0;
        m_req  = 1'b0;
        m_err  = 1'b1;
      end
      for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = ack_i;
    end
    m_ready = !m_busy && !m_hist[SS-1];
    cyc++;
  end

  always @(negedge clki) begin
    if (m_on) begin
      check1("s_ready", s_ready, m_ready);
      check1("req_o", req_o, m_req);
      checkw("data_o", data_o, m_data);
      check1("done", done, m_done);
      check1("err", err, m_err);
    end
  end

  int            done_cnt = 0;
  int            err_cnt  = 0;
  logic          req_prev = 1'b0;
  logic [DW-1:0] rise_q[$];

  always @(negedge clki) begin
    if (m_on) begin
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (req_o === 1'b1 && req_prev !== 1'b1) rise_q.push_back(data_o);
      req_prev = req_o;
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_word(input logic [DW-1:0] w, output int acc_cyc);
    int n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clki);
      n++;
    end
    check1("accept_in_time", n < 200, 1'b1);
    @(negedge clki);
    s_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_pulse(input bit want_err, input int limit, output int at_cyc);
    int n = 0;
    while (((want_err ? err : done) !== 1'b1) && n < limit) begin
      @(negedge clki);
      n++;
    end
    check1(want_err ? "err_in_time" : "done_in_time", n < limit, 1'b1);
    at_cyc = cyc;
  endtask

  initial begin
    int acc;
    int at;
    int d0;
    int e0;
    int n_hi;

    rst = 1'b1;
    repeat (3) @(negedge clki);
    check1("rst_req", req_o, 1'b0);
    checkw("rst_data", data_o, '0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_ready", s_ready, 1'b1);
    rst = 1'b0;
    @(negedge clki);

    // single word, ack looped back
    ack_loop = 1'b1;
    send_word(32'hA5A5_0001, acc);
    check1("first_req_rise", req_o, 1'b1);
    checkw("first_data", data_o, 32'hA5A5_0001);
    wait_pulse(1'b0, 50, at);
    checki("round_trip", at - acc, 2 * SS + 2);
    checkw("first_data_held", data_o, 32'hA5A5_0001);
    repeat (3) @(negedge clki);

    // three back-to-back words with s_valid held high
    rise_q.delete();
    d0 = done_cnt;
    s_valid = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      int n = 0;
      s_data = DW'(w);
      while (s_ready !== 1'b1 && n < 100) begin
        @(negedge clki);
        n++;
      end
      check1("b2b_accept_in_time", n < 100, 1'b1);
      @(negedge clki);
    end
    s_valid = 1'b0;
    repeat (20) @(negedge clki);
    checki("b2b_done_count", done_cnt - d0, 3);
    checki("b2b_rise_count", rise_q.size(), 3);
    for (int i = 0; i < 3 && i < rise_q.size(); i++) checkw("b2b_order", rise_q[i], DW'(i + 1));

    // stale high ack held through reset release
    ack_loop = 1'b0;
    ack_drv  = 1'b1;
    rst      = 1'b1;
    repeat (3) @(negedge clki);
    rst = 1'b0;
    repeat (3) @(negedge clki);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_0004;
    for (int i = 0; i < 5; i++) begin
      check1("stale_ack_ready", s_ready, 1'b0);
      check1("stale_ack_req", req_o, 1'b0);
      @(negedge clki);
    end
    ack_drv = 1'b0;
    @(negedge clki);
    check1("stale_ack_ready_1cyc", s_ready, 1'b0);
    @(negedge clki);
    check1("stale_ack_ready_2cyc", s_ready, 1'b1);
    @(negedge clki);
    s_valid  = 1'b0;
    ack_loop = 1'b1;
    wait_pulse(1'b0, 50, at);
    repeat (3) @(negedge clki);

    // reset mid-handshake while in REQ_HI
    ack_loop = 1'b0;
    ack_drv  = 1'b0;
    send_word(32'h0000_0035, acc);
    check1("midrst_in_req_hi", req_o, 1'b1);
    rst = 1'b1;
    @(negedge clki);
    rst = 1'b0;
    check1("midrst_req", req_o, 1'b0);
    checkw("midrst_data", data_o, '0);
    check1("midrst_done", done, 1'b0);
    check1("midrst_err", err, 1'b0);
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (20) @(negedge clki);
    checki("midrst_no_done", done_cnt - d0, 0);
    checki("midrst_no_err", err_cnt - e0, 0);

    // ack never arrives
    send_word(32'h0000_0036, acc);
`ifdef CDC_HS_TX_TIMEOUT_EN
    wait_pulse(1'b1, 50, at);
    checki("timeout_latency", at - acc, TO + 2);
    check1("timeout_req", req_o, 1'b0);
    check1("timeout_no_done", done, 1'b0);
    repeat (3) @(negedge clki);

    // awaited ack arrives on the same cycle the watchdog limit is reached
    send_word(32'h0000_0037, acc);
    repeat (7) @(negedge clki);
    ack_drv = 1'b1;
    @(negedge clki);
    @(negedge clki);
    check1("race_req_still_hi", req_o, 1'b1);
    e0 = err_cnt;
    @(negedge clki);
    check1("race_req_dropped", req_o, 1'b0);
    check1("race_no_err", err, 1'b0);
    ack_drv = 1'b0;
    wait_pulse(1'b0, 50, at);
    checki("race_err_count", err_cnt - e0, 0);
`else
    n_hi = 0;
    repeat (100) begin
      @(negedge clki);
      if (req_o === 1'b1) n_hi++;
    end
    checki("no_timeout_req_held", n_hi, 100);
    rst = 1'b1;
    @(negedge clki);
    rst = 1'b0;
`endif
    repeat (3) @(negedge clki);

    // randomized traffic with a lazy, occasionally glitching responder
    for (int i = 0; i < 1500; i++) begin
      s_valid = ($urandom_range(0, 1) == 1);
      s_data  = $urandom();
      if (ack_drv !== req_o && $urandom_range(0, 2) == 0) ack_drv = req_o;
      else if ($urandom_range(0, 60) == 0) ack_drv = ~ack_drv;
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clki);
    end
    rst     = 1'b0;
    s_valid = 1'b0;
    ack_drv = 1'b0;
    repeat (20) @(negedge clki);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
